// File: rtl/mem_access_if.sv
// Bundle of request/response and data-memory signals around the MEM-stage
// access unit. The master side is the access unit itself; the slave side is
// the pipeline plus the data memory.
interface mem_access_if #(
    parameter int ADDR_W = 10
) ();
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic [31:0]       req_pc;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic [ADDR_W-1:0] sp_out;
    logic              stall;
    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [15:0]       mem_write_data;
    logic [15:0]       mem_read_data;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_pc, mem_read_data,
        output req_ready, resp_valid, resp_data, sp_out, stall,
               mem_read_enable, mem_write_enable, mem_read_addr,
               mem_write_addr, mem_write_data
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_pc, mem_read_data,
        input  req_ready, resp_valid, resp_data, sp_out, stall,
               mem_read_enable, mem_write_enable, mem_read_addr,
               mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: sequences LDD/STD/PUSH/POP and two-word
// CALL/RET accesses onto a 16-bit memory, owns the stack pointer, and stalls
// the pipeline while an access is in flight. All memory-side outputs are
// registered; a read issued in cycle N returns data the cycle after N.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.master bus
);
    localparam logic [2:0] OP_LDD  = 3'd1;
    localparam logic [2:0] OP_STD  = 3'd2;
    localparam logic [2:0] OP_PUSH = 3'd3;
    localparam logic [2:0] OP_POP  = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;

    localparam logic [ADDR_W-1:0] SP_TOP = '1;
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO    = ADDR_W'(2);

    typedef enum logic [3:0] {
        IDLE, WR_HI, WR_LO, WR1, RD1, RD_WAIT, RD2, RD_WAIT2, RESP
    } state_t;

    state_t state, state_nxt;

    // Registered outputs and the context latched at acceptance.
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              is_ret_q, is_ret_d;   // distinguishes RET from LDD/POP in RD1
    logic [ADDR_W-1:0] addr2_q, addr2_d;     // address of the second word of CALL/RET
    logic [15:0]       wdata2_q, wdata2_d;   // low half of the CALL return address
    logic [15:0]       lo_q, lo_d;           // low word captured during RET

    logic accept;

    // Only real memory ops (1..6) are accepted, and only from IDLE.
    assign accept = (state == IDLE) && bus.req_valid &&
                    (bus.req_op >= OP_LDD) && (bus.req_op <= OP_RET);

    assign bus.req_ready        = (state == IDLE);
    assign bus.stall            = (state != IDLE);
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_data        = resp_data_q;
    assign bus.sp_out           = sp_q;
    assign bus.mem_write_enable = we_q;
    assign bus.mem_read_enable  = re_q;
    assign bus.mem_write_addr   = waddr_q;
    assign bus.mem_read_addr    = raddr_q;
    assign bus.mem_write_data   = wdata_q;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state sequencing for each op class.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.req_op)
                        OP_STD, OP_PUSH:       state_nxt = WR1;
                        OP_CALL:               state_nxt = WR_HI;
                        OP_LDD, OP_POP, OP_RET: state_nxt = RD1;
                        default:               state_nxt = IDLE;
                    endcase
                end
            end
            WR1:      state_nxt = IDLE;
            WR_HI:    state_nxt = WR_LO;
            WR_LO:    state_nxt = IDLE;
            RD1:      state_nxt = is_ret_q ? RD2 : RD_WAIT;
            RD_WAIT:  state_nxt = RESP;
            RD2:      state_nxt = RD_WAIT2;
            RD_WAIT2: state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Next values of the registered memory/response outputs and the stack
    // pointer; addresses are always formed from the pre-update SP.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        we_d         = 1'b0;
        re_d         = 1'b0;
        waddr_d      = '0;
        raddr_d      = '0;
        wdata_d      = '0;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        sp_d         = sp_q;
        is_ret_d     = is_ret_q;
        addr2_d      = addr2_q;
        wdata2_d     = wdata2_q;
        lo_d         = lo_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    is_ret_d = (bus.req_op == OP_RET);
                    case (bus.req_op)
                        OP_STD: begin
                            we_d = 1'b1; waddr_d = bus.req_addr;
                            wdata_d = bus.req_wdata; resp_valid_d = 1'b1;
                        end
                        OP_PUSH: begin
                            we_d = 1'b1; waddr_d = sp_q;
                            wdata_d = bus.req_wdata; resp_valid_d = 1'b1;
                            sp_d = sp_q - ONE;
                        end
                        OP_CALL: begin
                            we_d = 1'b1; waddr_d = sp_q;
                            wdata_d = bus.req_pc[31:16];
                            addr2_d = sp_q - ONE; wdata2_d = bus.req_pc[15:0];
                            sp_d = sp_q - TWO;
                        end
                        OP_LDD: begin
                            re_d = 1'b1; raddr_d = bus.req_addr;
                        end
                        OP_POP: begin
                            re_d = 1'b1; raddr_d = sp_q + ONE;
                            sp_d = sp_q + ONE;
                        end
                        OP_RET: begin
                            re_d = 1'b1; raddr_d = sp_q + ONE;
                            addr2_d = sp_q + TWO; sp_d = sp_q + TWO;
                        end
                        default: ;
                    endcase
                end
            end
            WR_HI: begin
                we_d = 1'b1; waddr_d = addr2_q; wdata_d = wdata2_q;
                resp_valid_d = 1'b1;
            end
            RD1: begin
                if (is_ret_q) begin
                    re_d = 1'b1; raddr_d = addr2_q;
                end
            end
            RD_WAIT: begin
                resp_valid_d = 1'b1;
                resp_data_d  = {16'h0000, bus.mem_read_data};
            end
            RD2:      lo_d = bus.mem_read_data;
            RD_WAIT2: begin
                resp_valid_d = 1'b1;
                resp_data_d  = {bus.mem_read_data, lo_q};
            end
            default: ;
        endcase
    end

    // Output, stack-pointer and context registers; reset aborts any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            waddr_q      <= '0;
            raddr_q      <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            sp_q         <= SP_TOP;
            is_ret_q     <= 1'b0;
            addr2_q      <= '0;
            wdata2_q     <= '0;
            lo_q         <= '0;
        end else begin
            we_q         <= we_d;
            re_q         <= re_d;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            sp_q         <= sp_d;
            is_ret_q     <= is_ret_d;
            addr2_q      <= addr2_d;
            wdata2_q     <= wdata2_d;
            lo_q         <= lo_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a cycle-by-cycle vector table for
// STD/LDD and PUSH/POP, then hand-written CALL/RET, SP wrap and reset-abort
// sequences. A behavioural 16-bit memory answers reads the way the real one
// does: address sampled on the rising edge, buffer updated on the falling edge.
module tb_mem_access_unit;
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDD  = 3'd1;
    localparam logic [2:0] OP_STD  = 3'd2;
    localparam logic [2:0] OP_PUSH = 3'd3;
    localparam logic [2:0] OP_POP  = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;
    localparam logic [2:0] OP_RSV  = 3'd7;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;

    mem_access_if #(.ADDR_W(10)) bus ();

    mem_access_unit #(.ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model.
    logic [15:0] mem [0:1023];
    logic        rd_pend;
    logic [9:0]  rd_addr_q;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            rd_pend   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            if (bus.mem_write_enable) mem[bus.mem_write_addr] <= bus.mem_write_data;
            rd_pend   <= bus.mem_read_enable;
            rd_addr_q <= bus.mem_read_addr;
        end
    end

    always @(negedge clk) begin
        if (rst) bus.mem_read_data <= 16'h0000;
        else if (rd_pend) bus.mem_read_data <= mem[rd_addr_q];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Invariants checked every cycle away from the active edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("we_re_exclusive", 32'(bus.mem_write_enable & bus.mem_read_enable), 32'h0);
            if (!bus.mem_write_enable)
                check("wr_bus_zero_when_idle", {6'h0, bus.mem_write_addr, bus.mem_write_data}, 32'h0);
            if (!bus.mem_read_enable)
                check("rd_addr_zero_when_idle", 32'(bus.mem_read_addr), 32'h0);
            check("stall_is_not_ready", 32'(bus.stall), 32'(!bus.req_ready));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [9:0] addr,
                         input logic [15:0] wd, input logic [31:0] pc);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_pc    = pc;
    endtask

    task automatic nop();
        drive(1'b0, OP_NOP, 10'h0, 16'h0, 32'h0);
    endtask

    // One row = one cycle: expected outputs seen in that cycle, inputs driven in it.
    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [9:0]  addr;
        logic [15:0] wd;
        logic [31:0] pc;
        logic        rdy;
        logic        we;
        logic        re;
        logic [9:0]  wa;
        logic [9:0]  ra;
        logic [15:0] wdo;
        logic        rv;
        logic [31:0] rd;
        logic [9:0]  sp;
    } vec_t;

    vec_t vecs [21];

    initial begin
        // v  op       addr    wd       pc     | rdy we re wa      ra      wdo      rv rd            sp
        vecs[0]  = '{1, OP_STD,  10'h005, 16'hBEEF, 32'h0, 1, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h00000000, 10'h3FF};
        vecs[1]  = '{1, OP_LDD,  10'h005, 16'h0000, 32'h0, 0, 1, 0, 10'h005, 10'h000, 16'hBEEF, 1, 32'h00000000, 10'h3FF};
        vecs[2]  = '{1, OP_LDD,  10'h005, 16'h0000, 32'h0, 1, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h00000000, 10'h3FF};
        vecs[3]  = '{0, OP_NOP,  10'h000, 16'h0000, 32'h0, 0, 0, 1, 10'h000, 10'h005, 16'h0000, 0, 32'h00000000, 10'h3FF};
        vecs[4]  = '{0, OP_NOP,  10'h000, 16'h0000, 32'h0, 0, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h00000000, 10'h3FF};
        vecs[5]  = '{0, OP_NOP,  10'h000, 16'h0000, 32'h0, 0, 0, 0, 10'h000, 10'h000, 16'h0000, 1, 32'h0000BEEF, 10'h3FF};
        vecs[6]  = '{1, OP_PUSH, 10'h000, 16'h1234, 32'h0, 1, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h0000BEEF, 10'h3FF};
        vecs[7]  = '{1, OP_PUSH, 10'h000, 16'h5678, 32'h0, 0, 1, 0, 10'h3FF, 10'h000, 16'h1234, 1, 32'h0000BEEF, 10'h3FE};
        vecs[8]  = '{1, OP_PUSH, 10'h000, 16'h5678, 32'h0, 1, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h0000BEEF, 10'h3FE};
        vecs[9]  = '{0, OP_NOP,  10'h000, 16'h0000, 32'h0, 0, 1, 0, 10'h3FE, 10'h000, 16'h5678, 1, 32'h0000BEEF, 10'h3FD};
        vecs[10] = '{1, OP_POP,  10'h000, 16'h0000, 32'h0, 1, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h0000BEEF, 10'h3FD};
        vecs[11] = '{0, OP_NOP,  10'h000, 16'h0000, 32'h0, 0, 0, 1, 10'h000, 10'h3FE, 16'h0000, 0, 32'h0000BEEF, 10'h3FE};
        vecs[12] = '{0, OP_NOP,  10'h000, 16'h0000, 32'h0, 0, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h0000BEEF, 10'h3FE};
        vecs[13] = '{0, OP_NOP,  10'h000, 16'h0000, 32'h0, 0, 0, 0, 10'h000, 10'h000, 16'h0000, 1, 32'h00005678, 10'h3FE};
        vecs[14] = '{1, OP_POP,  10'h000, 16'h0000, 32'h0, 1, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h00005678, 10'h3FE};
        vecs[15] = '{0, OP_NOP,  10'h000, 16'h0000, 32'h0, 0, 0, 1, 10'h000, 10'h3FF, 16'h0000, 0, 32'h00005678, 10'h3FF};
        vecs[16] = '{0, OP_NOP,  10'h000, 16'h0000, 32'h0, 0, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h00005678, 10'h3FF};
        vecs[17] = '{0, OP_NOP,  10'h000, 16'h0000, 32'h0, 0, 0, 0, 10'h000, 10'h000, 16'h0000, 1, 32'h00001234, 10'h3FF};
        vecs[18] = '{1, OP_RSV,  10'h123, 16'hFFFF, 32'h0, 1, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h00001234, 10'h3FF};
        vecs[19] = '{1, OP_NOP,  10'h123, 16'hFFFF, 32'h0, 1, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h00001234, 10'h3FF};
        vecs[20] = '{0, OP_NOP,  10'h000, 16'h0000, 32'h0, 1, 0, 0, 10'h000, 10'h000, 16'h0000, 0, 32'h00001234, 10'h3FF};

        // Reset, then idle with a valid NOP presented.
        rst = 1'b1;
        nop();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, OP_NOP, 10'h0, 16'h0, 32'h0);
        mon_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("idle%0d sp", c),        32'(bus.sp_out), 32'h3FF);
            check($sformatf("idle%0d ready", c),     32'(bus.req_ready), 32'h1);
            check($sformatf("idle%0d enables", c),   {30'h0, bus.mem_write_enable, bus.mem_read_enable}, 32'h0);
            check($sformatf("idle%0d resp_valid", c), 32'(bus.resp_valid), 32'h0);
            check($sformatf("idle%0d resp_data", c), bus.resp_data, 32'h0);
        end
        nop();

        // Vector table: STD/LDD, PUSH/PUSH/POP/POP, reserved op.
        for (int i = 0; i < 21; i++) begin
            step();
            check($sformatf("row%0d ready", i),      32'(bus.req_ready),        32'(vecs[i].rdy));
            check($sformatf("row%0d stall", i),      32'(bus.stall),            32'(!vecs[i].rdy));
            check($sformatf("row%0d we", i),         32'(bus.mem_write_enable), 32'(vecs[i].we));
            check($sformatf("row%0d re", i),         32'(bus.mem_read_enable),  32'(vecs[i].re));
            check($sformatf("row%0d waddr", i),      32'(bus.mem_write_addr),   32'(vecs[i].wa));
            check($sformatf("row%0d raddr", i),      32'(bus.mem_read_addr),    32'(vecs[i].ra));
            check($sformatf("row%0d wdata", i),      32'(bus.mem_write_data),   32'(vecs[i].wdo));
            check($sformatf("row%0d resp_valid", i), 32'(bus.resp_valid),       32'(vecs[i].rv));
            check($sformatf("row%0d resp_data", i),  bus.resp_data,             vecs[i].rd);
            check($sformatf("row%0d sp", i),         32'(bus.sp_out),           32'(vecs[i].sp));
            drive(vecs[i].v, vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].pc);
        end
        nop();

        // CALL at SP=0x3FF then RET.
        drive(1'b1, OP_CALL, 10'h0, 16'h0, 32'hCAFE0010);
        step(); nop();
        check("call hi we",    32'(bus.mem_write_enable), 32'h1);
        check("call hi addr",  32'(bus.mem_write_addr), 32'h3FF);
        check("call hi data",  32'(bus.mem_write_data), 32'hCAFE);
        check("call hi rv",    32'(bus.resp_valid), 32'h0);
        check("call sp",       32'(bus.sp_out), 32'h3FD);
        step();
        check("call lo addr",  32'(bus.mem_write_addr), 32'h3FE);
        check("call lo data",  32'(bus.mem_write_data), 32'h0010);
        check("call lo rv",    32'(bus.resp_valid), 32'h1);
        step();
        check("call done ready", 32'(bus.req_ready), 32'h1);
        check("call mem hi",   32'(mem[10'h3FF]), 32'hCAFE);
        check("call mem lo",   32'(mem[10'h3FE]), 32'h0010);
        drive(1'b1, OP_RET, 10'h0, 16'h0, 32'h0);
        step(); nop();
        check("ret rd1 re",    32'(bus.mem_read_enable), 32'h1);
        check("ret rd1 addr",  32'(bus.mem_read_addr), 32'h3FE);
        check("ret sp",        32'(bus.sp_out), 32'h3FF);
        step();
        check("ret rd2 re",    32'(bus.mem_read_enable), 32'h1);
        check("ret rd2 addr",  32'(bus.mem_read_addr), 32'h3FF);
        step();
        check("ret wait re",   32'(bus.mem_read_enable), 32'h0);
        check("ret wait rv",   32'(bus.resp_valid), 32'h0);
        step();
        check("ret rv",        32'(bus.resp_valid), 32'h1);
        check("ret data",      bus.resp_data, 32'hCAFE0010);
        step();
        check("ret done ready", 32'(bus.req_ready), 32'h1);
        check("ret done rv",   32'(bus.resp_valid), 32'h0);

        // Upward wrap: STD a marker at 0, POP from SP=0x3FF reads address 0.
        drive(1'b1, OP_STD, 10'h000, 16'hA5A5, 32'h0);
        step(); nop();
        check("wrap std addr", 32'(bus.mem_write_addr), 32'h000);
        step();
        drive(1'b1, OP_POP, 10'h0, 16'h0, 32'h0);
        step(); nop();
        check("wrap pop addr", 32'(bus.mem_read_addr), 32'h000);
        check("wrap pop sp",   32'(bus.sp_out), 32'h000);
        step(); step();
        check("wrap pop rv",   32'(bus.resp_valid), 32'h1);
        check("wrap pop data", bus.resp_data, 32'h0000A5A5);
        step();
        // Downward wrap: CALL at SP=0.
        drive(1'b1, OP_CALL, 10'h0, 16'h0, 32'h13572468);
        step(); nop();
        check("wcall hi addr", 32'(bus.mem_write_addr), 32'h000);
        check("wcall hi data", 32'(bus.mem_write_data), 32'h1357);
        check("wcall sp",      32'(bus.sp_out), 32'h3FE);
        step();
        check("wcall lo addr", 32'(bus.mem_write_addr), 32'h3FF);
        check("wcall lo data", 32'(bus.mem_write_data), 32'h2468);
        step();
        drive(1'b1, OP_RET, 10'h0, 16'h0, 32'h0);
        step(); nop();
        check("wret rd1 addr", 32'(bus.mem_read_addr), 32'h3FF);
        step();
        check("wret rd2 addr", 32'(bus.mem_read_addr), 32'h000);
        step(); step();
        check("wret data",     bus.resp_data, 32'h13572468);
        check("wret sp",       32'(bus.sp_out), 32'h000);
        step();

        // Reset asserted in A+2 of a RET aborts it.
        drive(1'b1, OP_RET, 10'h0, 16'h0, 32'h0);
        step(); nop();
        step();
        rst = 1'b1;
        step();
        check("rst enables",   {30'h0, bus.mem_write_enable, bus.mem_read_enable}, 32'h0);
        check("rst rv",        32'(bus.resp_valid), 32'h0);
        check("rst sp",        32'(bus.sp_out), 32'h3FF);
        check("rst resp_data", bus.resp_data, 32'h0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("post_rst%0d ready", c), 32'(bus.req_ready), 32'h1);
            check($sformatf("post_rst%0d rv", c),    32'(bus.resp_valid), 32'h0);
            check($sformatf("post_rst%0d sp", c),    32'(bus.sp_out), 32'h3FF);
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
